// File: rtl/minesweeper_pkg.sv
// Shared tile codes and FSM state type for the minesweeper display path.
package minesweeper_pkg;

    typedef logic [3:0] tile_code_t;

    localparam tile_code_t MAX_COUNT          = 4'd8;
    localparam tile_code_t CODE_HIDDEN_SAFE   = 4'd9;
    localparam tile_code_t CODE_MINE_HIDDEN   = 4'd10;
    localparam tile_code_t CODE_MINE_HIT      = 4'd11;
    localparam tile_code_t CODE_RESERVED_MIN  = 4'd12;
    localparam tile_code_t CODE_RESERVED_MAX  = 4'd14;
    localparam tile_code_t CODE_INVALID       = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StCommit
    } snap_state_t;

endpackage

// File: rtl/board_stat_accum.sv
// Per-capture tile classification: counts revealed cells, hit mines and hidden mines.
module board_stat_accum
    import minesweeper_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 cap_en,
    input  tile_code_t           code,
    output logic [CNT_WIDTH-1:0] revealed_cnt,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] hidden_mine_cnt
);

    logic [CNT_WIDTH-1:0] revealed_q, hit_q, hidden_mine_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            revealed_q    <= '0;
            hit_q         <= '0;
            hidden_mine_q <= '0;
        end else if (clear) begin
            revealed_q    <= '0;
            hit_q         <= '0;
            hidden_mine_q <= '0;
        end else if (cap_en) begin
            if (code <= MAX_COUNT) begin
                revealed_q <= revealed_q + 1'b1;
            end
            if (code == CODE_MINE_HIT) begin
                hit_q <= hit_q + 1'b1;
            end
            if (code == CODE_MINE_HIDDEN) begin
                hidden_mine_q <= hidden_mine_q + 1'b1;
            end
        end
    end

    assign revealed_cnt    = revealed_q;
    assign hit_cnt         = hit_q;
    assign hidden_mine_cnt = hidden_mine_q;

endmodule

// File: rtl/board_snapshot_reader.sv
// Sweeps the board memory display port each frame and commits an atomic shadow copy.
// Optional macro SNAPSHOT_CODE_CHECK_EN adds a sticky code_err flag for reserved codes.
module board_snapshot_reader
    import minesweeper_pkg::*;
#(
    parameter int unsigned ROWS          = 5,
    parameter int unsigned COLS          = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned READ_LATENCY  = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               frame_start,
    output logic [ADDRESS_WIDTH-1:0]           rd_addr,
    input  logic [DATA_WIDTH-1:0]              rd_data,
    input  logic [$clog2(ROWS*COLS)-1:0]       cell_sel,
    output logic [3:0]                         cell_code,
    output logic                               busy,
    output logic                               snap_done,
    output logic                               snap_valid,
    output logic [$clog2(ROWS*COLS+1)-1:0]     revealed_cnt,
    output logic                               mine_hit,
    output logic                               win
`ifdef SNAPSHOT_CODE_CHECK_EN
    ,
    output logic                               code_err
`endif
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [IW-1:0] LastIdx   = IW'(N - 1);
    localparam logic [1:0]    DrainLast = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    snap_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    drain_q, drain_d;
    logic          scan_start, scan_active, commit;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        scan_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d    = StScan;
                    idx_d      = '0;
                    scan_start = 1'b1;
                end
            end
            StScan: begin
                if (idx_q == LastIdx) begin
                    state_d = (READ_LATENCY > 0) ? StDrain : StCommit;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StCommit;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    assign scan_active = (state_q == StScan);
    assign commit      = (state_q == StCommit);
    assign busy        = (state_q != StIdle);
    assign snap_done   = commit;
    // idx_q holds after a scan, so the address holds too.
    assign rd_addr     = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(idx_q);

    // Capture point trails the address by READ_LATENCY cycles.
    logic          cap_en;
    logic [IW-1:0] cap_idx;

    if (READ_LATENCY == 0) begin : g_lat0
        assign cap_en  = scan_active;
        assign cap_idx = idx_q;
    end else begin : g_latn
        logic [READ_LATENCY-1:0] vld_pipe_q;
        logic [IW-1:0]           idx_pipe_q [READ_LATENCY];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_pipe_q <= '0;
                for (int i = 0; i < READ_LATENCY; i++) idx_pipe_q[i] <= '0;
            end else begin
                vld_pipe_q[0] <= scan_active;
                idx_pipe_q[0] <= idx_q;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vld_pipe_q[i] <= vld_pipe_q[i-1];
                    idx_pipe_q[i] <= idx_pipe_q[i-1];
                end
            end
        end

        assign cap_en  = vld_pipe_q[READ_LATENCY-1];
        assign cap_idx = idx_pipe_q[READ_LATENCY-1];
    end

    tile_code_t cap_code;
    assign cap_code = (rd_data > DATA_WIDTH'(CODE_RESERVED_MAX)) ? CODE_INVALID : rd_data[3:0];

    tile_code_t staging_q [N];
    tile_code_t shadow_q  [N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staging_q <= '{default: CODE_INVALID};
        end else if (cap_en) begin
            staging_q[cap_idx] <= cap_code;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '{default: CODE_INVALID};
        end else if (commit) begin
            shadow_q <= staging_q;
        end
    end

    assign cell_code = ({1'b0, cell_sel} < (IW + 1)'(N)) ? shadow_q[cell_sel] : CODE_INVALID;

    logic [CW-1:0] rev_acc, hit_acc, hm_acc;

    board_stat_accum #(
        .CNT_WIDTH (CW)
    ) u_stat_accum (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (scan_start),
        .cap_en          (cap_en),
        .code            (cap_code),
        .revealed_cnt    (rev_acc),
        .hit_cnt         (hit_acc),
        .hidden_mine_cnt (hm_acc)
    );

    logic [CW-1:0] revealed_q;
    logic          mine_hit_q, win_q, snap_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            revealed_q   <= '0;
            mine_hit_q   <= 1'b0;
            win_q        <= 1'b0;
            snap_valid_q <= 1'b0;
        end else if (commit) begin
            revealed_q   <= rev_acc;
            mine_hit_q   <= (hit_acc != '0);
            win_q        <= (rev_acc == CW'(N) - hm_acc) && (hit_acc == '0);
            snap_valid_q <= 1'b1;
        end
    end

    assign revealed_cnt = revealed_q;
    assign mine_hit     = mine_hit_q;
    assign win          = win_q;
    assign snap_valid   = snap_valid_q;

`ifdef SNAPSHOT_CODE_CHECK_EN
    logic err_acc_q, code_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_acc_q  <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            if (scan_start) begin
                err_acc_q <= 1'b0;
            end else if (cap_en && (cap_code >= CODE_RESERVED_MIN)) begin
                err_acc_q <= 1'b1;
            end
            if (commit && err_acc_q) begin
                code_err_q <= 1'b1;
            end
        end
    end

    assign code_err = code_err_q;
`endif

endmodule

// File: tb/tb_board_snapshot_reader.sv
// Bench for board_snapshot_reader: READ_LATENCY 0 and 2 instances share one memory image.
module tb_board_snapshot_reader;

    localparam int N = 25;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [4:0]  cell_sel = '0;
    logic [11:0] rd_addr0, rd_addr2;
    logic [31:0] rd_data0, rd_data2, p1, p2;
    logic [3:0]  cell_code0, cell_code2;
    logic        busy0, busy2, done0_s, done2_s, valid0, valid2, hit0, hit2, win0, win2;
    logic [4:0]  rev0, rev2;
`ifdef SNAPSHOT_CODE_CHECK_EN
    logic        err0, err2;
`endif

    logic [31:0] mem [N];
    logic [31:0] mem_next [N];

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] exp_shadow [N];
    int         exp_rev;
    logic       exp_hit, exp_win, exp_valid, exp_err;

    always #5 clk = ~clk;

    always_comb rd_data0 = (rd_addr0 < 12'(N)) ? mem[rd_addr0] : 32'h0;
    always @(posedge clk) begin
        p1 <= (rd_addr2 < 12'(N)) ? mem[rd_addr2] : 32'h0;
        p2 <= p1;
    end
    assign rd_data2 = p2;

    board_snapshot_reader dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .rd_addr      (rd_addr0),
        .rd_data      (rd_data0),
        .cell_sel     (cell_sel),
        .cell_code    (cell_code0),
        .busy         (busy0),
        .snap_done    (done0_s),
        .snap_valid   (valid0),
        .revealed_cnt (rev0),
        .mine_hit     (hit0),
        .win          (win0)
`ifdef SNAPSHOT_CODE_CHECK_EN
        ,
        .code_err     (err0)
`endif
    );

    board_snapshot_reader #(
        .READ_LATENCY (2)
    ) dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .rd_addr      (rd_addr2),
        .rd_data      (rd_data2),
        .cell_sel     (cell_sel),
        .cell_code    (cell_code2),
        .busy         (busy2),
        .snap_done    (done2_s),
        .snap_valid   (valid2),
        .revealed_cnt (rev2),
        .mine_hit     (hit2),
        .win          (win2)
`ifdef SNAPSHOT_CODE_CHECK_EN
        ,
        .code_err     (err2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sat(input logic [31:0] v);
        return (v > 32'd14) ? 4'd15 : v[3:0];
    endfunction

    function automatic logic [31:0] rand_val();
        int r;
        r = $urandom_range(0, 15);
        if (r == 15) return $urandom;
        if (r >= 13) return 32'($urandom_range(12, 20));
        return 32'($urandom_range(0, 11));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) exp_shadow[k] = 4'd15;
        exp_rev = 0;
        exp_hit = 1'b0;
        exp_win = 1'b0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
    endtask

    // Board rules applied to a completed snapshot of raw memory words.
    task automatic model_commit(input logic [31:0] cap [N]);
        int hidden_mines;
        hidden_mines = 0;
        exp_rev = 0;
        exp_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_shadow[k] = sat(cap[k]);
            if (exp_shadow[k] <= 4'd8) exp_rev++;
            if (exp_shadow[k] == 4'd10) hidden_mines++;
            if (exp_shadow[k] == 4'd11) exp_hit = 1'b1;
            if (exp_shadow[k] >= 4'd12) exp_err = 1'b1;
        end
        exp_win = (exp_rev == N - hidden_mines) && !exp_hit;
        exp_valid = 1'b1;
    endtask

    // One frame: optional retrigger at step retrig_at, memory swap at step change_at.
    task automatic run_frame(input int retrig_at, input int change_at);
        int done0, done2, pulses0, pulses2, busy0c, busy2c, sel;
        logic [3:0]  old_code;
        logic [31:0] cap [N];
        done0 = 0; done2 = 0; pulses0 = 0; pulses2 = 0; busy0c = 0; busy2c = 0;
        for (int k = 0; k < N; k++)
            cap[k] = (change_at > 0 && k >= change_at - 1) ? mem_next[k] : mem[k];
        sel = $urandom_range(0, N - 1);
        cell_sel = 5'(sel);
        old_code = exp_shadow[sel];
        frame_start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 40; n++) begin
            frame_start = (n == retrig_at);
            if (n == change_at) for (int k = 0; k < N; k++) mem[k] = mem_next[k];
            if (done0_s) begin pulses0++; if (done0 == 0) done0 = n; end
            if (done2_s) begin pulses2++; if (done2 == 0) done2 = n; end
            if (busy0) busy0c++;
            if (busy2) busy2c++;
            if (done0 == 0) check("hold_l0", {28'h0, cell_code0}, {28'h0, old_code});
            if (done2 == 0) check("hold_l2", {28'h0, cell_code2}, {28'h0, old_code});
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
        check("latency_l0", done0, 26);
        check("latency_l2", done2, 28);
        check("pulses_l0", pulses0, 1);
        check("pulses_l2", pulses2, 1);
        check("busy_cycles_l0", busy0c, 26);
        check("busy_cycles_l2", busy2c, 28);
        model_commit(cap);
    endtask

    task automatic check_all();
        check("idle_busy_l0", {31'h0, busy0}, 0);
        check("idle_busy_l2", {31'h0, busy2}, 0);
        check("addr_hold_l0", {20'h0, rd_addr0}, N - 1);
        check("addr_hold_l2", {20'h0, rd_addr2}, N - 1);
        check("revealed_l0", {27'h0, rev0}, exp_rev);
        check("revealed_l2", {27'h0, rev2}, exp_rev);
        check("mine_hit_l0", {31'h0, hit0}, {31'h0, exp_hit});
        check("mine_hit_l2", {31'h0, hit2}, {31'h0, exp_hit});
        check("win_l0", {31'h0, win0}, {31'h0, exp_win});
        check("win_l2", {31'h0, win2}, {31'h0, exp_win});
        check("valid_l0", {31'h0, valid0}, {31'h0, exp_valid});
        check("valid_l2", {31'h0, valid2}, {31'h0, exp_valid});
`ifdef SNAPSHOT_CODE_CHECK_EN
        check("code_err_l0", {31'h0, err0}, {31'h0, exp_err});
        check("code_err_l2", {31'h0, err2}, {31'h0, exp_err});
`endif
        for (int k = 0; k < N + 2; k++) begin
            cell_sel = (k < N) ? 5'(k) : 5'($urandom_range(N, 31));
            @(negedge clk);
            check("cell_l0", {28'h0, cell_code0}, (k < N) ? {28'h0, exp_shadow[k]} : 32'd15);
            check("cell_l2", {28'h0, cell_code2}, (k < N) ? {28'h0, exp_shadow[k]} : 32'd15);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin mem[k] = '0; mem_next[k] = '0; end
        model_reset();
        cell_sel = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy0 | busy2}, 0);
        check("rst_done", {31'h0, done0_s | done2_s}, 0);
        check("rst_valid", {31'h0, valid0 | valid2}, 0);
        check("rst_status", {rev0, rev2, hit0, hit2, win0, win2}, 0);
        check("rst_addr", {rd_addr0, rd_addr2}, 0);
        check("rst_cell", {cell_code0, cell_code2}, 8'hff);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // All hidden safe except one hidden mine.
        for (int k = 0; k < N; k++) mem[k] = 32'd9;
        mem[0] = 32'd10;
        run_frame(0, 0);
        check_all();
        check("t1_revealed", {27'h0, rev0}, 0);

        // One hit mine among revealed cells.
        for (int k = 0; k < N; k++) mem[k] = 32'($urandom_range(0, 8));
        mem[12] = 32'd11;
        run_frame(0, 0);
        check_all();
        check("t2_revealed", {27'h0, rev0}, 24);
        check("t2_mine_hit", {31'h0, hit0}, 1);

        // Winning board.
        for (int k = 0; k < N; k++) mem[k] = 32'd1;
        mem[7] = 32'd10;
        run_frame(0, 0);
        check_all();
        check("t3_win", {31'h0, win0 & win2}, 1);

        // Value k at address k: reserved and saturated codes.
        for (int k = 0; k < N; k++) mem[k] = 32'(k);
        run_frame(0, 0);
        check_all();

        // Retrigger during scan plus memory swap at scan step 11.
        for (int k = 0; k < N; k++) begin mem[k] = rand_val(); mem_next[k] = rand_val(); end
        run_frame(5, 11);
        check_all();

        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < N; k++) mem[k] = rand_val();
            run_frame(0, 0);
            check_all();
        end

        // Reset at scan cycle 10.
        cell_sel = 5'($urandom_range(0, N - 1));
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", {31'h0, busy0 | busy2}, 0);
        check("mid_rst_valid", {31'h0, valid0 | valid2}, 0);
        check("mid_rst_cell", {cell_code0, cell_code2}, 8'hff);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) mem[k] = rand_val();
        run_frame(0, 0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
